// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, derived totals and pixel/sync payload types.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned RGB_W        = 24;

  // Total period of one axis: active + front porch + sync + back porch.
  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned H_TOTAL_DEF = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int unsigned V_TOTAL_DEF = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  typedef logic [RGB_W-1:0] rgb888_t;

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic de;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, de: 1'b0};

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } lock_state_e;

endpackage

// File: rtl/vga_timing_gen_lock_qualifier.sv
// Synchronizes PLL lock and holds the raster off until lock has been stable for LOCK_WAIT clocks.
module lock_qualifier
  import vga_pkg::*;
#(
  parameter int unsigned LOCK_WAIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  output logic run
);

  localparam int unsigned CW = $clog2(LOCK_WAIT + 1);

  logic [1:0]    sync_q;
  logic          lk_s;
  logic [CW-1:0] cnt_q;
  lock_state_e   state_q, state_d;

  assign lk_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], pll_locked};
  end

  // Saturating stable-lock counter; any dropout restarts qualification.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           cnt_q <= '0;
    else if (!lk_s)                    cnt_q <= '0;
    else if (cnt_q != CW'(LOCK_WAIT))  cnt_q <= cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WAIT_LOCK;
    else     state_q <= state_d;
  end

  // Enter RUN on the same edge the counter saturates.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_LOCK: if (lk_s && (cnt_q >= CW'(LOCK_WAIT - 1))) state_d = RUN;
      RUN:       if (!lk_s) state_d = WAIT_LOCK;
    endcase
  end

  assign run = (state_q == RUN);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: fetch-timeline counters, sync delay line matched to frame-buffer latency.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned LOCK_WAIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pll_locked,
  input  rgb888_t     pix_in,
  output logic        fetch_en,
  output logic [9:0]  fetch_x,
  output logic [8:0]  fetch_y,
  output logic        frame_start,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output rgb888_t     vga_rgb
);

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC;

  logic          run;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last, v_last;
  logic          fetch_en_c, frame_start_c;
  sync_t         s0_c, s0_q;
  sync_t         dly_q [RD_LAT];

  lock_qualifier #(.LOCK_WAIT(LOCK_WAIT)) u_lock (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .run        (run)
  );

  assign h_last = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last = (v_cnt == VW'(V_TOTAL - 1));

  // Raster counters; parked at the origin whenever lock is not qualified.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  always_comb begin
    fetch_en_c    = 1'b0;
    frame_start_c = 1'b0;
    s0_c          = SYNC_IDLE;
    fetch_en_c    = run && (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    frame_start_c = run && (h_cnt == '0) && (v_cnt == '0);
    s0_c.hs_n     = !((h_cnt >= HW'(HS_BEG)) && (h_cnt < HW'(HS_END)));
    s0_c.vs_n     = !((v_cnt >= VW'(VS_BEG)) && (v_cnt < VW'(VS_END)));
    s0_c.de       = fetch_en_c;
  end

  // Stage 0: fetch request and its matching sync/blank word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_en    <= 1'b0;
      fetch_x     <= '0;
      fetch_y     <= '0;
      frame_start <= 1'b0;
      s0_q        <= SYNC_IDLE;
    end else begin
      fetch_en    <= fetch_en_c;
      fetch_x     <= fetch_en_c ? 10'(h_cnt) : '0;
      fetch_y     <= fetch_en_c ? 9'(v_cnt) : '0;
      frame_start <= frame_start_c;
      s0_q        <= s0_c;
    end
  end

  // Delay line matching the frame-buffer read latency; flushed on lock loss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) dly_q[i] <= SYNC_IDLE;
    end else if (!run) begin
      for (int unsigned i = 0; i < RD_LAT; i++) dly_q[i] <= SYNC_IDLE;
    end else begin
      dly_q[0] <= s0_q;
      for (int unsigned i = 1; i < RD_LAT; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_hs  <= 1'b1;
      vga_vs  <= 1'b1;
      vga_de  <= 1'b0;
      vga_rgb <= '0;
    end else if (!run) begin
      vga_hs  <= 1'b1;
      vga_vs  <= 1'b1;
      vga_de  <= 1'b0;
      vga_rgb <= '0;
    end else begin
      vga_hs  <= dly_q[RD_LAT-1].hs_n;
      vga_vs  <= dly_q[RD_LAT-1].vs_n;
      vga_de  <= dly_q[RD_LAT-1].de;
      vga_rgb <= dly_q[RD_LAT-1].de ? pix_in : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a scaled-down raster (16x10 total, 8x4 active).
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 2, VS = 2, VB = 2;
  localparam int LAT = 2, LW = 16;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pll_locked = 1'b0;
  logic [23:0] pix_in;
  logic        fetch_en, frame_start, vga_hs, vga_vs, vga_de;
  logic [9:0]  fetch_x;
  logic [8:0]  fetch_y;
  logic [23:0] vga_rgb;
  logic [23:0] p1 = '0, p2 = '0;

  int checks = 0;
  int errors = 0;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .RD_LAT(LAT), .LOCK_WAIT(LW)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .pix_in(pix_in),
    .fetch_en(fetch_en), .fetch_x(fetch_x), .fetch_y(fetch_y), .frame_start(frame_start),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de), .vga_rgb(vga_rgb)
  );

  always #5 clk = ~clk;

  // Frame-buffer model: returns the fetched coordinate two clocks later, junk otherwise.
  always @(posedge clk) begin
    p1 <= fetch_en ? {5'd0, fetch_x, fetch_y} : 24'hABCDEF;
    p2 <= p1;
  end
  assign pix_in = p2;

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (fetch_en !== 1'b0)    begin errors++; $display("FAIL reset_fetch_en got %b want 0", fetch_en); end
    checks++; if (fetch_x !== 10'd0)    begin errors++; $display("FAIL reset_fetch_x got %0d want 0", fetch_x); end
    checks++; if (fetch_y !== 9'd0)     begin errors++; $display("FAIL reset_fetch_y got %0d want 0", fetch_y); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b want 0", frame_start); end
    checks++; if (vga_hs !== 1'b1)      begin errors++; $display("FAIL reset_hs got %b want 1", vga_hs); end
    checks++; if (vga_vs !== 1'b1)      begin errors++; $display("FAIL reset_vs got %b want 1", vga_vs); end
    checks++; if (vga_de !== 1'b0)      begin errors++; $display("FAIL reset_de got %b want 0", vga_de); end
    checks++; if (vga_rgb !== 24'd0)    begin errors++; $display("FAIL reset_rgb got %h want 0", vga_rgb); end
    rst = 1'b0;
  endtask

  // Raise lock and wait for the first fetch; returns at the negedge where it is seen.
  task automatic wait_first_fetch(input string tag);
    int n;
    n = 0;
    pll_locked = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (fetch_en === 1'b1) begin n = i; break; end
    end
    checks++; if (n < LW + 1 || n > LW + 3) begin errors++; $display("FAIL %s_latency got %0d clocks want %0d..%0d (0=timeout)", tag, n, LW + 1, LW + 3); end
    checks++; if (fetch_x !== 10'd0)    begin errors++; $display("FAIL %s_first_x got %0d want 0", tag, fetch_x); end
    checks++; if (fetch_y !== 9'd0)     begin errors++; $display("FAIL %s_first_y got %0d want 0", tag, fetch_y); end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL %s_first_frame_start got %b want 1", tag, frame_start); end
  endtask

  task automatic test_lock;
    @(negedge clk);
    wait_first_fetch("lock");
  endtask

  // Cycle-by-cycle raster model over two frames plus line/frame statistics.
  task automatic test_raster;
    int h, v, hj, vj;
    logic e_fe, e_fs, e_hs, e_vs, e_de;
    logic [9:0] e_x;
    logic [8:0] e_y;
    logic [23:0] e_rgb;
    int fe_line = 0, hs_line = 0, hs_first = -1, vs_frame = 0, vs_first = -1, fs_prev = -1, fs_cnt = 0;
    for (int k = 0; k < 2 * FT + 4; k++) begin
      if (k > 0) @(negedge clk);
      h = k % HT; v = (k / HT) % VT;
      e_fe = (h < HA) && (v < VA);
      e_x  = e_fe ? 10'(h) : 10'd0;
      e_y  = e_fe ? 9'(v) : 9'd0;
      e_fs = (h == 0) && (v == 0);
      e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_rgb = 24'd0;
      if (k >= LAT + 1) begin
        hj = (k - LAT - 1) % HT; vj = ((k - LAT - 1) / HT) % VT;
        e_hs  = !((hj >= HA + HF) && (hj < HA + HF + HS));
        e_vs  = !((vj >= VA + VF) && (vj < VA + VF + VS));
        e_de  = (hj < HA) && (vj < VA);
        e_rgb = e_de ? {5'd0, 10'(hj), 9'(vj)} : 24'd0;
      end
      checks++; if (fetch_en !== e_fe)    begin errors++; $display("FAIL raster_fetch_en k=%0d got %b want %b", k, fetch_en, e_fe); end
      checks++; if (fetch_x !== e_x)      begin errors++; $display("FAIL raster_fetch_x k=%0d got %0d want %0d", k, fetch_x, e_x); end
      checks++; if (fetch_y !== e_y)      begin errors++; $display("FAIL raster_fetch_y k=%0d got %0d want %0d", k, fetch_y, e_y); end
      checks++; if (frame_start !== e_fs) begin errors++; $display("FAIL raster_frame_start k=%0d got %b want %b", k, frame_start, e_fs); end
      checks++; if (vga_hs !== e_hs)      begin errors++; $display("FAIL raster_hs k=%0d got %b want %b", k, vga_hs, e_hs); end
      checks++; if (vga_vs !== e_vs)      begin errors++; $display("FAIL raster_vs k=%0d got %b want %b", k, vga_vs, e_vs); end
      checks++; if (vga_de !== e_de)      begin errors++; $display("FAIL raster_de k=%0d got %b want %b", k, vga_de, e_de); end
      checks++; if (vga_rgb !== e_rgb)    begin errors++; $display("FAIL raster_rgb k=%0d got %h want %h", k, vga_rgb, e_rgb); end
      if (k < HT && fetch_en === 1'b1) fe_line++;
      if (k >= LAT + 1 && k < LAT + 1 + HT && vga_hs === 1'b0) begin hs_line++; if (hs_first < 0) hs_first = k; end
      if (k >= LAT + 1 && k < LAT + 1 + FT && vga_vs === 1'b0) begin vs_frame++; if (vs_first < 0) vs_first = k; end
      if (frame_start === 1'b1) begin
        if (fs_prev >= 0) begin
          checks++; if (k - fs_prev != FT) begin errors++; $display("FAIL frame_period got %0d want %0d", k - fs_prev, FT); end
        end
        fs_prev = k; fs_cnt++;
      end
    end
    checks++; if (fe_line != HA)                    begin errors++; $display("FAIL line_fetch_count got %0d want %0d", fe_line, HA); end
    checks++; if (hs_line != HS)                    begin errors++; $display("FAIL line_hs_width got %0d want %0d", hs_line, HS); end
    checks++; if (hs_first != LAT + 1 + HA + HF)    begin errors++; $display("FAIL line_hs_start got %0d want %0d", hs_first, LAT + 1 + HA + HF); end
    checks++; if (vs_frame != VS * HT)              begin errors++; $display("FAIL frame_vs_width got %0d want %0d", vs_frame, VS * HT); end
    checks++; if (vs_first != LAT + 1 + (VA + VF) * HT) begin errors++; $display("FAIL frame_vs_start got %0d want %0d", vs_first, LAT + 1 + (VA + VF) * HT); end
    checks++; if (fs_cnt != 3)                      begin errors++; $display("FAIL frame_start_count got %0d want 3", fs_cnt); end
  endtask

  task automatic test_lock_loss;
    int n;
    bit bad;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      if (fetch_en === 1'b1 && fetch_x == 10'd5 && fetch_y == 9'd2) begin n = 1; break; end
      @(negedge clk);
    end
    checks++; if (n == 0) begin errors++; $display("FAIL lockloss_find got timeout want pixel 5 line 2"); end
    pll_locked = 1'b0;
    n = 0;
    for (int i = 1; i <= LAT + 3; i++) begin
      @(negedge clk);
      if (vga_de === 1'b0 && vga_hs === 1'b1 && vga_vs === 1'b1 && vga_rgb === 24'd0 && fetch_en === 1'b0) begin n = i; break; end
    end
    checks++; if (n == 0) begin errors++; $display("FAIL lockloss_blank got de=%b hs=%b vs=%b fe=%b want idle within %0d clocks", vga_de, vga_hs, vga_vs, fetch_en, LAT + 3); end
    bad = 1'b0;
    for (int i = 0; i < 2 * HT; i++) begin
      @(negedge clk);
      if (vga_de !== 1'b0 || vga_hs !== 1'b1 || vga_vs !== 1'b1 || fetch_en !== 1'b0 || frame_start !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL lockloss_hold got activity while unlocked want idle"); end
    wait_first_fetch("relock");
    @(negedge clk);
    checks++; if (fetch_x !== 10'd1 || fetch_y !== 9'd0) begin errors++; $display("FAIL relock_second got %0d,%0d want 1,0", fetch_x, fetch_y); end
  endtask

  task automatic test_async_reset;
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (fetch_en === 1'b1 && fetch_x == 10'd3) begin n = 1; break; end
      @(negedge clk);
    end
    checks++; if (n == 0) begin errors++; $display("FAIL areset_find got timeout want pixel 3"); end
    #2 rst = 1'b1;
    #1;
    checks++; if (fetch_en !== 1'b0)    begin errors++; $display("FAIL areset_fetch_en got %b want 0", fetch_en); end
    checks++; if (fetch_x !== 10'd0)    begin errors++; $display("FAIL areset_fetch_x got %0d want 0", fetch_x); end
    checks++; if (fetch_y !== 9'd0)     begin errors++; $display("FAIL areset_fetch_y got %0d want 0", fetch_y); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL areset_frame_start got %b want 0", frame_start); end
    checks++; if (vga_hs !== 1'b1)      begin errors++; $display("FAIL areset_hs got %b want 1", vga_hs); end
    checks++; if (vga_vs !== 1'b1)      begin errors++; $display("FAIL areset_vs got %b want 1", vga_vs); end
    checks++; if (vga_de !== 1'b0)      begin errors++; $display("FAIL areset_de got %b want 0", vga_de); end
    checks++; if (vga_rgb !== 24'd0)    begin errors++; $display("FAIL areset_rgb got %h want 0", vga_rgb); end
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (fetch_en !== 1'b0) begin errors++; $display("FAIL areset_requalify got fetch_en=%b want 0", fetch_en); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_raster();
    test_lock_loss();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got no completion want finish before 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
